keypad_cmd_encoder: RTL and testbench

Scans a 4x4 matrix keypad, synchronizes and debounces the column returns, and emits one 4-bit calculator command per key press. The command is a single-cycle strobe. The block is the producer side of the `cmd[3:0]` interface consumed by `Calculadora_Top`. It sits between the board keypad pins and the calculator core and uses the same command encoding.

---
 rtl/keypad_cmd_encoder.sv | 150 +++++++++++++++
 tb/tb_keypad_cmd_encoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_cmd_encoder.sv
// 4x4 keypad scanner: synchronizes/debounces column returns and emits one cmd strobe per key press.
// Latency: press-to-strobe at most 4*SCAN_DIV+DEBOUNCE_CYC+3 cycles; no backpressure, every strobe must be taken.
module keypad_cmd_encoder #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] cmd,
  output logic       cmd_valid
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    row, row_nxt;
  logic [1:0]    col, col_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic [3:0]    cmd_nxt;
  logic          cmd_valid_nxt;
  logic [3:0]    col_meta, col_s;
  logic [1:0]    low_col;

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'b0001;
      4'h1: code = 4'b0010;
      4'h2: code = 4'b0011;
      4'h3: code = 4'b1010;
      4'h4: code = 4'b0100;
      4'h5: code = 4'b0101;
      4'h6: code = 4'b0110;
      4'h7: code = 4'b1011;
      4'h8: code = 4'b0111;
      4'h9: code = 4'b1000;
      4'ha: code = 4'b1001;
      4'hb: code = 4'b1100;
      4'hc: code = 4'b1111;
      4'hd: code = 4'b0000;
      4'he: code = 4'b1110;
      default: code = 4'b1101;
    endcase
    return code;
  endfunction

  // Lowest-index low column wins when several keys in the row are down.
  always_comb begin
    low_col = 2'd3;
    if (!col_s[0])      low_col = 2'd0;
    else if (!col_s[1]) low_col = 2'd1;
    else if (!col_s[2]) low_col = 2'd2;
  end

  assign row_out = ~(4'b0001 << row);

  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    col_nxt       = col;
    slot_nxt      = slot;
    cnt_nxt       = cnt;
    cmd_nxt       = cmd;
    cmd_valid_nxt = 1'b0;
    case (state)
      SCAN: begin
        if (slot == SLOT_LAST) begin
          slot_nxt = '0;
          if (col_s != 4'b1111) begin
            col_nxt   = low_col;
            cnt_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else begin
            row_nxt = row + 2'd1;
          end
        end else begin
          slot_nxt = slot + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s[col]) begin
          cnt_nxt   = '0;
          slot_nxt  = '0;
          row_nxt   = row + 2'd1;
          state_nxt = SCAN;
        end else if (cnt == DB_LAST) begin
          cnt_nxt       = '0;
          cmd_nxt       = keymap(row, col);
          cmd_valid_nxt = 1'b1;
          state_nxt     = EMIT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      EMIT: begin
        cnt_nxt   = '0;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        // Any key still down (in this row) restarts the release window.
        if (col_s != 4'b1111) begin
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          cnt_nxt   = '0;
          slot_nxt  = '0;
          row_nxt   = row + 2'd1;
          state_nxt = SCAN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = SCAN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SCAN;
      row       <= 2'd0;
      col       <= 2'd0;
      slot      <= '0;
      cnt       <= '0;
      cmd       <= 4'b0000;
      cmd_valid <= 1'b0;
      col_meta  <= 4'b1111;
      col_s     <= 4'b1111;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      col       <= col_nxt;
      slot      <= slot_nxt;
      cnt       <= cnt_nxt;
      cmd       <= cmd_nxt;
      cmd_valid <= cmd_valid_nxt;
      col_meta  <= col_in;
      col_s     <= col_meta;
    end
  end

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// Directed bench for keypad_cmd_encoder with a behavioural keypad matrix model.
module tb_keypad_cmd_encoder;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [15:0] keys;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] pulses[$];

  typedef struct {
    string      name;
    logic [15:0] keys;
    int         hold;
    int         gap;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[8];

  keypad_cmd_encoder #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .col_in    (col_in),
    .row_out   (row_out),
    .cmd       (cmd),
    .cmd_valid (cmd_valid)
  );

  always #5 clock = ~clock;

  // Key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(negedge clock) if (cmd_valid) pulses.push_back(cmd);

  function automatic logic [15:0] k(input int r, input int c);
    return 16'(1) << (r*4 + c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    logic [3:0] er;
    logic [3:0] first;
    logic [3:0] prev;
    logic [3:0] seq[2];

    vecs[0] = '{"single_3",   k(0,2),          60,  40, 4'b0011};
    vecs[1] = '{"seq_3",      k(0,2),          40,  30, 4'b0011};
    vecs[2] = '{"seq_plus",   k(0,3),          40,  30, 4'b1010};
    vecs[3] = '{"seq_1",      k(0,0),          40,  30, 4'b0001};
    vecs[4] = '{"seq_eq",     k(3,2),          40,  30, 4'b1110};
    vecs[5] = '{"hold_eq",    k(3,2),          500, 40, 4'b1110};
    vecs[6] = '{"multi_5_6",  k(1,1) | k(1,2), 40,  40, 4'b0101};
    vecs[7] = '{"div",        k(3,3),          40,  40, 4'b1101};

    reset = 1'b1;
    keys  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_row_out", row_out, 4'b1110);
    check("rst_cmd", cmd, 4'b0000);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Idle scan: each row held for SCAN_DIV cycles.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      er = ~(4'b0001 << (i / 4));
      check($sformatf("scan_row_%0d", i), row_out, er);
    end

    for (int v = 0; v < 8; v++) begin
      pulses.delete();
      keys = vecs[v].keys;
      cyc(vecs[v].hold);
      keys = '0;
      cyc(vecs[v].gap);
      first = (pulses.size() > 0) ? pulses[0] : 4'bxxxx;
      check({vecs[v].name, "_npulse"}, pulses.size(), 1);
      check({vecs[v].name, "_code"}, first, vecs[v].exp);
      check({vecs[v].name, "_cmd_hold"}, cmd, vecs[v].exp);
    end

    // Bounce: 3-cycle bursts with 1-cycle opens never reach the debounce count.
    pulses.delete();
    for (int b = 0; b < 12; b++) begin
      keys = k(2,1);
      cyc(3);
      keys = '0;
      cyc(1);
    end
    check("bounce_npulse_bursts", pulses.size(), 0);
    keys = k(2,1);
    cyc(40);
    keys = '0;
    cyc(30);
    first = (pulses.size() > 0) ? pulses[0] : 4'bxxxx;
    check("bounce_npulse", pulses.size(), 1);
    check("bounce_code", first, 4'b1000);

    // Reset in the middle of DEBOUNCE for key x (r2,c3).
    pulses.delete();
    @(negedge clock);
    n = 0;
    while (row_out == 4'b1011 && n < 20) begin
      @(negedge clock);
      n++;
    end
    keys = k(2,3);
    n = 0;
    while (row_out != 4'b1011 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("rst_mid_row2", row_out, 4'b1011);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_mid_row_out", row_out, 4'b1110);
    check("rst_mid_cmd", cmd, 4'b0000);
    check("rst_mid_cmd_valid", cmd_valid, 1'b0);
    check("rst_mid_no_pulse", pulses.size(), 0);
    n = 0;
    while (!cmd_valid && n < 28) begin
      @(negedge clock);
      n++;
    end
    check("rst_mid_latency", n, 20);
    check("rst_mid_code", cmd, 4'b1100);
    keys = '0;
    cyc(30);
    check("rst_mid_npulse", pulses.size(), 1);

    // Row wrap after releasing clear (r3,c0).
    pulses.delete();
    @(negedge clock);
    keys = k(3,0);
    n = 0;
    while (!cmd_valid && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("wrap_code", cmd, 4'b1111);
    check("wrap_row_held", row_out, 4'b0111);
    keys = '0;
    prev = row_out;
    seq[0] = 4'b0000;
    seq[1] = 4'b0000;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (row_out != prev) begin
        if (n < 2) seq[n] = row_out;
        n++;
        prev = row_out;
      end
    end
    check("wrap_seq0", seq[0], 4'b1110);
    check("wrap_seq1", seq[1], 4'b1101);
    check("wrap_npulse", pulses.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
